// File: rtl/ex_mdu.sv
// Iterative RV32/64 M-extension multiply/divide unit: one product or quotient bit per cycle,
// with single-cycle fast paths for divide-by-zero and signed-overflow division.
`timescale 1ns/1ps
module ex_mdu #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_opr_a_i,
    input  logic [XLEN-1:0] req_opr_b_i,
    input  logic [RD_W-1:0] req_rd_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_res_o,
    output logic [RD_W-1:0] resp_rd_o,
    output logic            busy_o
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ALL1   = '1;
    localparam logic [XLEN-1:0] MINNEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                div_q, div_d;
    logic                sel_q, sel_d;     // mul: return high half; div: return remainder
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [RD_W-1:0]     rd_q, rd_d;

    // Request decode
    logic            a_sgn_en, b_sgn_en, a_neg, b_neg;
    logic            is_div, is_rem, div0, ovf, accept;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;

    always_comb begin
        a_sgn_en = (req_op_i == OP_MULH) | (req_op_i == OP_MULHSU) |
                   (req_op_i == OP_DIV)  | (req_op_i == OP_REM);
        b_sgn_en = (req_op_i == OP_MULH) | (req_op_i == OP_DIV) | (req_op_i == OP_REM);
        a_neg    = a_sgn_en & req_opr_a_i[XLEN-1];
        b_neg    = b_sgn_en & req_opr_b_i[XLEN-1];
        a_mag    = a_neg ? -req_opr_a_i : req_opr_a_i;
        b_mag    = b_neg ? -req_opr_b_i : req_opr_b_i;
        is_div   = req_op_i[2];
        is_rem   = req_op_i[2] & req_op_i[1];
        div0     = is_div & (req_opr_b_i == '0);
        ovf      = ((req_op_i == OP_DIV) | (req_op_i == OP_REM)) &
                   (req_opr_a_i == MINNEG) & (req_opr_b_i == ALL1);
        if (div0) fast_res = is_rem ? req_opr_a_i : ALL1;
        else      fast_res = is_rem ? '0 : req_opr_a_i;
    end

    assign req_ready_o  = rst_ni & (state_q == S_IDLE) & ~flush_i;
    assign accept       = req_valid_i & req_ready_o;
    assign resp_valid_o = (state_q == S_DONE);
    assign busy_o       = (state_q != S_IDLE);
    assign resp_res_o   = res_q;
    assign resp_rd_o    = rd_q;

    // One iteration step. Both algorithms keep the running value in acc_q:
    // multiply shifts right (multiplier in low half), divide shifts left (dividend/quotient in low half).
    logic [XLEN:0]     mul_sum, div_rsh, div_diff;
    logic [2*XLEN-1:0] mul_nxt, div_nxt, step, full;
    logic [XLEN-1:0]   mul_res, div_val, div_res, fin;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        mul_nxt  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        div_rsh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff = div_rsh - {1'b0, b_q};
        div_nxt  = div_diff[XLEN] ? {div_rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        step     = div_q ? div_nxt : mul_nxt;
        full     = neg_q ? -step : step;
        mul_res  = sel_q ? full[2*XLEN-1:XLEN] : full[XLEN-1:0];
        div_val  = sel_q ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
        div_res  = neg_q ? -div_val : div_val;
        fin      = div_q ? div_res : mul_res;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sel_d   = sel_q;
        neg_d   = neg_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        rd_d    = rd_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    div_d = is_div;
                    sel_d = is_div ? is_rem : (req_op_i != OP_MUL);
                    neg_d = is_rem ? a_neg : (a_neg ^ b_neg);
                    b_d   = b_mag;
                    acc_d = {{XLEN{1'b0}}, a_mag};
                    rd_d  = req_rd_i;
                    if (div0 | ovf) begin
                        res_d   = fast_res;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = CW'(XLEN - 1);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = step;
                if (cnt_q == '0) begin
                    res_d   = fin;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over both accept and the response handshake.
        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sel_q   <= 1'b0;
            neg_q   <= 1'b0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sel_q   <= sel_d;
            neg_q   <= neg_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: a 32-bit and a 64-bit instance checked against a
// wide-integer arithmetic model of the RISC-V M-extension rules.
`timescale 1ns/1ps
module tb_ex_mdu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // 32-bit instance
    logic        rv0 = 0, rr0 = 1, fl0 = 0, rdy0, vv0, busy0;
    logic [2:0]  op0 = 0;
    logic [31:0] a0 = 0, b0 = 0, res0;
    logic [4:0]  rd0 = 0, rdo0;
    // 64-bit instance
    logic        rv1 = 0, rr1 = 1, fl1 = 0, rdy1, vv1, busy1;
    logic [2:0]  op1 = 0;
    logic [63:0] a1 = 0, b1 = 0, res1;
    logic [4:0]  rd1 = 0, rdo1;

    ex_mdu #(.XLEN(32), .RD_W(5)) u32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl0), .req_valid_i(rv0), .req_ready_o(rdy0),
        .req_op_i(op0), .req_opr_a_i(a0), .req_opr_b_i(b0), .req_rd_i(rd0),
        .resp_valid_o(vv0), .resp_ready_i(rr0), .resp_res_o(res0), .resp_rd_o(rdo0), .busy_o(busy0));

    ex_mdu #(.XLEN(64), .RD_W(5)) u64 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(fl1), .req_valid_i(rv1), .req_ready_o(rdy1),
        .req_op_i(op1), .req_opr_a_i(a1), .req_opr_b_i(b1), .req_rd_i(rd1),
        .resp_valid_o(vv1), .resp_ready_i(rr1), .resp_res_o(res1), .resp_rd_o(rdo1), .busy_o(busy1));

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    logic        seen [2] = '{1'b0, 1'b0};
    logic [63:0] eres [2];
    logic [4:0]  erd  [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mask(input int xl);
        return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xl) - 64'd1);
    endfunction

    // Reference: exact integer arithmetic in 128 bits, then truncate to XLEN.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int xl);
        logic [63:0]         m;
        logic signed [127:0] ua, ub, sa, sb, p;
        m  = mask(xl);
        ua = $signed({64'd0, a & m});
        ub = $signed({64'd0, b & m});
        sa = a[xl-1] ? ua - (128'sd1 <<< xl) : ua;
        sb = b[xl-1] ? ub - (128'sd1 <<< xl) : ub;
        p  = '0;
        case (op)
            3'd0: p = ua * ub;
            3'd1: p = (sa * sb) >>> xl;
            3'd2: p = (sa * ub) >>> xl;
            3'd3: p = (ua * ub) >>> xl;
            3'd4: p = (ub == '0) ? -128'sd1 : sa / sb;
            3'd5: p = (ub == '0) ? -128'sd1 : ua / ub;
            3'd6: p = (ub == '0) ? ua : sa % sb;
            default: p = (ub == '0) ? ua : ua % ub;
        endcase
        return p[63:0] & m;
    endfunction

    function automatic logic [63:0] pick(input int xl);
        logic [63:0] m, v;
        m = mask(xl);
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = m;
            2: v = 64'd1 << (xl - 1);
            3: v = 64'($urandom_range(0, 9));
            4: v = m - 64'($urandom_range(0, 9));
            default: v = {$urandom, $urandom};
        endcase
        return v & m;
    endfunction

    task automatic mon(input int ch, input logic v, input logic rin, input logic rdy,
                       input logic [63:0] res, input logic [4:0] rd);
        exp_t e;
        int   n;
        if (!v) return;
        if (!seen[ch]) begin
            n = (ch == 0) ? q0.size() : q1.size();
            if (n == 0) begin
                chk($sformatf("ch%0d_unexpected_resp", ch), 64'(v), 64'd0);
                return;
            end
            if (ch == 0) e = q0.pop_front();
            else         e = q1.pop_front();
            chk($sformatf("ch%0d_latency", ch), 64'(cyc - e.acc + 1), 64'(e.lat));
            eres[ch] = e.res;
            erd[ch]  = e.rd;
            seen[ch] = 1'b1;
        end
        chk($sformatf("ch%0d_res", ch), res, eres[ch]);
        chk($sformatf("ch%0d_rd", ch), 64'(rd), 64'(erd[ch]));
        chk($sformatf("ch%0d_ready_in_done", ch), 64'(rdy), 64'd0);
        if (rin) seen[ch] = 1'b0;
    endtask

    always @(negedge clk) begin
        mon(0, vv0, rr0, rdy0, {32'd0, res0}, rdo0);
        mon(1, vv1, rr1, rdy1, res1, rdo1);
    end

    task automatic issue(input int ch, input logic [2:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input bit push);
        int          g, xl;
        logic [63:0] m;
        exp_t        e;
        bit          fast;
        xl = (ch == 0) ? 32 : 64;
        m  = mask(xl);
        @(posedge clk); #2;
        if (ch == 0) begin rv0 = 1; op0 = op; a0 = a[31:0]; b0 = b[31:0]; rd0 = rd; end
        else         begin rv1 = 1; op1 = op; a1 = a; b1 = b; rd1 = rd; end
        g = 0;
        while (!((ch == 0) ? rdy0 : rdy1) && g < 300) begin
            @(posedge clk); #2;
            g++;
        end
        if (g >= 300) begin
            chk($sformatf("ch%0d_accept_timeout", ch), 64'd1, 64'd0);
            rv0 = 0; rv1 = 0;
            return;
        end
        @(posedge clk); #1;
        e.acc = cyc;
        #1;
        if (ch == 0) rv0 = 0; else rv1 = 0;
        fast = op[2] && (((b & m) == '0) ||
               (((op == 3'd4) || (op == 3'd6)) && ((a & m) == (64'd1 << (xl - 1))) && ((b & m) == m)));
        e.lat = fast ? 1 : xl + 1;
        e.res = model(op, a, b, xl);
        e.rd  = rd;
        if (push) begin
            if (ch == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic wait_v(input int ch);
        int g = 0;
        while (!((ch == 0) ? vv0 : vv1) && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) chk($sformatf("ch%0d_valid_timeout", ch), 64'd1, 64'd0);
    endtask

    task automatic drain();
        int g = 0;
        while ((q0.size() != 0 || q1.size() != 0 || vv0 || vv1) && g < 500) begin
            @(negedge clk);
            g++;
        end
        if (g >= 500) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", 64'(rdy0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_valid", 64'(vv0), 64'd0);
        chk("rst_res", 64'(res0), 64'd0);
        chk("rst_rd", 64'(rdo0), 64'd0);
        chk("rst_ready64", 64'(rdy1), 64'd0);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_rst", 64'(rdy0), 64'd1);

        // Directed arithmetic cases
        issue(0, 3'd0, 64'd7, 64'hFFFF_FFFD, 5'd3, 1);
        issue(0, 3'd1, 64'h8000_0000, 64'h8000_0000, 5'd4, 1);
        issue(0, 3'd2, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd5, 1);
        issue(0, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 5'd6, 1);
        issue(0, 3'd4, 64'hFFFF_FFF9, 64'd2, 5'd7, 1);
        issue(0, 3'd6, 64'hFFFF_FFF9, 64'd2, 5'd8, 1);
        issue(0, 3'd5, 64'hFFFF_FFF9, 64'd2, 5'd9, 1);
        issue(0, 3'd5, 64'd5, 64'd0, 5'd10, 1);
        issue(0, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 5'd11, 1);
        issue(0, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd12, 1);
        issue(0, 3'd7, 64'h1234_5678, 64'd0, 5'd13, 1);

        for (int i = 0; i < 40; i++)
            issue(0, 3'($urandom_range(0, 7)), pick(32), pick(32), 5'($urandom_range(0, 31)), 1);
        drain();

        // Flush in CALC cycle 10: no response, idle next cycle
        issue(0, 3'd0, 64'd5, 64'd9, 5'd1, 0);
        repeat (9) @(posedge clk);
        #2 fl0 = 1;
        @(posedge clk);
        #2 fl0 = 0;
        @(negedge clk);
        chk("flush_busy", 64'(busy0), 64'd0);
        chk("flush_ready", 64'(rdy0), 64'd1);
        chk("flush_valid", 64'(vv0), 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_no_resp", 64'(vv0), 64'd0);
        // Flush blocks a same-cycle accept
        @(posedge clk);
        #2 fl0 = 1; rv0 = 1; op0 = 3'd0;
        #1 chk("flush_blocks_ready", 64'(rdy0), 64'd0);
        @(posedge clk);
        #1 chk("flush_no_accept", 64'(busy0), 64'd0);
        #1 fl0 = 0; rv0 = 0;
        issue(0, 3'd0, 64'd2, 64'd3, 5'd2, 1);
        drain();

        // Backpressure: result held stable in DONE
        rr0 = 0;
        issue(0, 3'd5, 64'($urandom), 64'($urandom_range(1, 1000)), 5'd17, 1);
        wait_v(0);
        repeat (5) @(negedge clk);
        chk("hold_busy", 64'(busy0), 64'd1);
        @(posedge clk);
        #2 rr0 = 1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_hs", 64'(busy0), 64'd0);
        chk("valid_after_hs", 64'(vv0), 64'd0);

        // Reset mid-CALC drops the operation
        issue(0, 3'd4, 64'd100, 64'd7, 5'd2, 0);
        repeat (5) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_busy", 64'(busy0), 64'd0);
        chk("midrst_valid", 64'(vv0), 64'd0);
        chk("midrst_ready", 64'(rdy0), 64'd0);
        chk("midrst_res", 64'(res0), 64'd0);
        @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        chk("ready_after_midrst", 64'(rdy0), 64'd1);
        repeat (40) @(negedge clk);
        issue(0, 3'd4, 64'd100, 64'd7, 5'd21, 1);
        drain();

        // 64-bit instance with backpressure, then random traffic
        rr1 = 0;
        issue(1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1);
        wait_v(1);
        repeat (5) @(negedge clk);
        chk("hold_busy64", 64'(busy1), 64'd1);
        @(posedge clk);
        #2 rr1 = 1;
        issue(1, 3'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd8, 1);
        issue(1, 3'd6, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 1);
        for (int i = 0; i < 12; i++)
            issue(1, 3'($urandom_range(0, 7)), pick(64), pick(64), 5'($urandom_range(0, 31)), 1);
        drain();

        chk("sb_empty", 64'(q0.size() + q1.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
